// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: UART receive front end.
// Synchronizes rx_in, detects the start edge, samples each bit at mid-bit on
// the oversampling tick and assembles the data LSB-first. At the stop-bit
// sample it presents data_out/stop_bit with a one-cycle check_stop strobe.
// Optional feature macro: RX_MAJORITY_EN (3-sample majority vote per bit).
module uart_rx_deserializer #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 stop_bit,
  output logic                 check_stop,
  output logic                 start_error,
  output logic                 busy
);

  localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int S     = OVERSAMPLE / 2 - 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_S    = CNT_W'(S);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t               state_reg;
  logic                 rx_meta_reg;
  logic                 rx_sync_reg;
  logic                 rx_prev_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [BIT_W-1:0]     bit_idx_reg;
  logic [DATA_BITS-1:0] sr_reg;
  logic [DATA_BITS-1:0] data_out_reg;
  logic                 stop_bit_reg;
  logic                 check_stop_reg;
  logic                 start_error_reg;
  logic                 busy_reg;

  logic                 sample_point;
  logic                 sample_val;
  logic                 last_tick;

  // Two-flop synchronizer on the asynchronous line; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx_in;
      rx_sync_reg <= rx_meta_reg;
    end
  end

`ifdef RX_MAJORITY_EN
  localparam logic [CNT_W-1:0] CNT_S_EARLY = CNT_W'(S - 1);
  localparam logic [CNT_W-1:0] CNT_S_LATE  = CNT_W'(S + 1);

  logic smp_early_reg;
  logic smp_mid_reg;

  // Capture the first two of the three votes; the third is the live line.
  always_ff @(posedge clk) begin
    if (rst) begin
      smp_early_reg <= 1'b1;
      smp_mid_reg   <= 1'b1;
    end else if (baud_tick) begin
      if (cnt_reg == CNT_S_EARLY) smp_early_reg <= rx_sync_reg;
      if (cnt_reg == CNT_S)       smp_mid_reg   <= rx_sync_reg;
    end
  end

  // Decision one tick after mid-bit, by 2-of-3 majority.
  always_comb begin
    sample_point = baud_tick && (cnt_reg == CNT_S_LATE);
    sample_val   = (smp_early_reg & smp_mid_reg) |
                   (smp_early_reg & rx_sync_reg) |
                   (smp_mid_reg   & rx_sync_reg);
  end
`else
  // Single sample taken exactly at mid-bit.
  always_comb begin
    sample_point = baud_tick && (cnt_reg == CNT_S);
    sample_val   = rx_sync_reg;
  end
`endif

  assign last_tick = baud_tick && (cnt_reg == CNT_LAST);

  // Frame FSM: bit timing, shifting, and the registered output strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      rx_prev_reg     <= 1'b1;
      cnt_reg         <= '0;
      bit_idx_reg     <= '0;
      sr_reg          <= '0;
      data_out_reg    <= '0;
      stop_bit_reg    <= 1'b1;
      check_stop_reg  <= 1'b0;
      start_error_reg <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      check_stop_reg  <= 1'b0;
      start_error_reg <= 1'b0;
      if (baud_tick) begin
        rx_prev_reg <= rx_sync_reg;
        case (state_reg)
          ST_IDLE: begin
            // Only a high-to-low transition starts a frame, so a line stuck
            // low after a framing error must rise again first.
            if (rx_prev_reg && !rx_sync_reg) begin
              state_reg <= ST_START;
              cnt_reg   <= '0;
              busy_reg  <= 1'b1;
            end
          end
          ST_START: begin
            if (sample_point && sample_val) begin
              start_error_reg <= 1'b1;
              busy_reg        <= 1'b0;
              state_reg       <= ST_IDLE;
              cnt_reg         <= '0;
            end else if (last_tick) begin
              state_reg   <= ST_DATA;
              cnt_reg     <= '0;
              bit_idx_reg <= '0;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
          ST_DATA: begin
            if (sample_point) begin
              sr_reg <= DATA_BITS'({sample_val, sr_reg} >> 1);
            end
            if (last_tick) begin
              cnt_reg <= '0;
              if (bit_idx_reg == BIT_LAST) begin
                state_reg   <= ST_STOP;
                bit_idx_reg <= '0;
              end else begin
                bit_idx_reg <= bit_idx_reg + BIT_W'(1);
              end
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
          ST_STOP: begin
            // Leave at mid-stop so a back-to-back start edge is not missed.
            if (sample_point) begin
              data_out_reg   <= sr_reg;
              stop_bit_reg   <= sample_val;
              check_stop_reg <= 1'b1;
              busy_reg       <= 1'b0;
              state_reg      <= ST_IDLE;
              cnt_reg        <= '0;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
          default: begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_out    = data_out_reg;
  assign stop_bit    = stop_bit_reg;
  assign check_stop  = check_stop_reg;
  assign start_error = start_error_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Testbench for uart_rx_deserializer: drives tick-level line waveforms,
// predicts each receive event from the waveform with a mid-bit sampling
// model, and checks DUT strobes through a scoreboard queue.
// Honors RX_MAJORITY_EN the same way as the design.
module tb_uart_rx_deserializer;

  logic       clk;
  logic       rst;
  logic       baud_tick;
  logic       rx_in;
  logic [7:0] data_out;
  logic       stop_bit;
  logic       check_stop;
  logic       start_error;
  logic       busy;

  uart_rx_deserializer #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_tick  (baud_tick),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .stop_bit   (stop_bit),
    .check_stop (check_stop),
    .start_error(start_error),
    .busy       (busy)
  );

  typedef struct {
    bit         is_start_err;
    logic [7:0] data;
    logic       stop;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         cs_cycle[$];
  logic [7:0] last_data = 8'h00;
  logic       wave [0:255];
  int         wave_len;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // One-cycle baud tick every 4 clocks.
  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 baud_tick = 1'b1;
      @(posedge clk);
      #1 baud_tick = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_tick();
    do @(posedge clk); while (baud_tick !== 1'b1);
  endtask

  // A value driven after one tick is first seen at the following tick; with
  // the start edge detected on wave[0], mid-bit of frame bit b is wave[16b+8].
  function automatic logic samp(input int b);
    int idx;
    idx = 16 * b + 8;
`ifdef RX_MAJORITY_EN
    return (wave[idx-1] & wave[idx]) | (wave[idx-1] & wave[idx+1]) | (wave[idx] & wave[idx+1]);
`else
    return wave[idx];
`endif
  endfunction

  // Build a full frame plus trailing idle ticks; glitch_pos < 0 means none.
  task automatic build_frame(input logic [7:0] d, input logic stop, input int gap, input int glitch_pos);
    for (int t = 0; t < 160 + gap; t++) begin
      if (t < 16)       wave[t] = 1'b0;
      else if (t < 144) wave[t] = d[(t / 16) - 1];
      else if (t < 160) wave[t] = stop;
      else              wave[t] = 1'b1;
    end
    if (glitch_pos >= 0) wave[glitch_pos] = ~wave[glitch_pos];
    wave_len = 160 + gap;
  endtask

  // Expected result derived from the line waveform itself.
  task automatic push_frame_expect();
    exp_t e;
    e.is_start_err = 1'b0;
    for (int b = 0; b < 8; b++) e.data[b] = samp(b + 1);
    e.stop = samp(9);
    exp_q.push_back(e);
  endtask

  task automatic send_wave(input int len, input bit mid_check);
    for (int t = 0; t < len; t++) begin
      wait_tick();
      #1 rx_in = wave[t];
      if (mid_check && t == 80) check("busy_mid_frame", busy, 1);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int gap, input int glitch_pos);
    build_frame(d, stop, gap, glitch_pos);
    push_frame_expect();
    send_wave(wave_len, 1'b1);
  endtask

  task automatic send_false_start(input int low_ticks);
    exp_t e;
    for (int t = 0; t < 24; t++) wave[t] = (t < low_ticks) ? 1'b0 : 1'b1;
    e.is_start_err = 1'b1;
    e.data = 8'h00;
    e.stop = 1'b1;
    exp_q.push_back(e);
    send_wave(24, 1'b0);
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Scoreboard monitor: every strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (rst) begin
      last_data = 8'h00;
    end else if (check_stop === 1'b1 || start_error === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_strobe: got check_stop=%0b start_error=%0b expected none",
                 check_stop, start_error);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.is_start_err) begin
          $display("rx false start: data_out=%02h", data_out);
          check("start_error_strobe", {start_error, check_stop}, 2'b10);
          check("data_hold_after_false_start", data_out, last_data);
          check("busy_after_false_start", busy, 0);
        end else begin
          $display("rx frame: data=%02h stop=%0b (expect %02h/%0b)", data_out, stop_bit, e.data, e.stop);
          cs_cycle.push_back(cyc);
          check("check_stop_strobe", {check_stop, start_error}, 2'b10);
          check("frame_data", data_out, e.data);
          check("frame_stop_bit", stop_bit, e.stop);
          check("busy_after_frame", busy, 0);
          last_data = e.data;
        end
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_data_out"}, data_out, 8'h00);
    check({tag, "_stop_bit"}, stop_bit, 1);
    check({tag, "_check_stop"}, check_stop, 0);
    check({tag, "_start_error"}, start_error, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int base;
    int gap;
    logic st;
    rst   = 1'b1;
    rx_in = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    #1 rst = 1'b0;
    repeat (20) wait_tick();

    // Basic frame.
    send_frame(8'hA5, 1'b1, 4, -1);
    drain("drain_a5");

    // False start: 3 ticks low, then high.
    send_false_start(3);
    drain("drain_false_start");

    // Framing error followed by a good frame once the line is high again.
    send_frame(8'h3C, 1'b0, 2, -1);
    send_frame(8'h5A, 1'b1, 3, -1);
    drain("drain_framing");

    // Reset during data bit 3 of 0xFF, then a clean 0x5A.
    build_frame(8'hFF, 1'b1, 0, -1);
    send_wave(16 * 4 + 8, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_values("midframe_reset");
    rx_in = 1'b1;
    repeat (4) wait_tick();
    send_frame(8'h5A, 1'b1, 4, -1);
    drain("drain_after_reset");

    // Single-tick glitch at the mid-bit of data bit 2.
    send_frame(8'hFF, 1'b1, 4, 16 * 3 + 8);
    drain("drain_glitch");

    // Back-to-back frames: strobes must be 10 bit periods (640 clk) apart.
    base = cs_cycle.size();
    send_frame(8'h01, 1'b1, 0, -1);
    send_frame(8'h80, 1'b1, 4, -1);
    drain("drain_b2b");
    check("b2b_strobe_count", cs_cycle.size() - base, 2);
    if (cs_cycle.size() >= base + 2)
      check("b2b_spacing", cs_cycle[base + 1] - cs_cycle[base], 640);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 99) < 15) begin
        send_false_start($urandom_range(1, 6));
      end else begin
        st  = ($urandom_range(0, 3) != 0);
        gap = $urandom_range(0, 3);
        if (!st && gap == 0) gap = 1;
        send_frame($urandom_range(0, 255), st, gap,
                   ($urandom_range(0, 1) != 0) ? int'($urandom_range(16, 143)) : -1);
      end
    end
    drain("drain_random");
    repeat (10) wait_tick();
    check("final_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Receiver front end of the UART: synchronizes the serial line, detects the start bit, samples data bits at mid-bit using an oversampling tick, and assembles them LSB-first into a byte. At the stop-bit sample point it presents the byte, the sampled stop-bit level and a one-cycle `check_stop` strobe to the downstream stop-bit checker. That checker validates the frame and forwards the data or flags `stop_error`.

## Interface
- `OVERSAMPLE`, 16: `baud_tick` pulses per bit period; even, ≥ 8.
- `DATA_BITS`, 8: data bits per frame.
- `clk` input 1: single clock; everything is rising-edge.
- `rst` input 1: reset, synchronous and active-high.
- `baud_tick` input 1: one-`clk` enable at `OVERSAMPLE`× baud rate.
- `rx_in` input 1: asynchronous serial line, idle high.
- `data_out` output `DATA_BITS`: assembled byte; stable from the `check_stop` pulse until the next frame's stop sample.
- `stop_bit` output 1: sampled stop-bit level; feeds the checker's line input.
- `check_stop` output 1: one-`clk` strobe when `data_out`/`stop_bit` are valid.
- `start_error` output 1: one-`clk` strobe on a false start.
- `busy` output 1: high in any state other than IDLE.

## Operation
- `rx_in` passes through a 2-flop synchronizer (`rx_sync`); both flops reset to 1. `rx_prev` holds `rx_sync` from the previous `baud_tick`.
- The tick counter `cnt` runs 0..`OVERSAMPLE`-1, advances only on `baud_tick`, and wraps to 0 at each bit boundary. `bit_idx` runs 0..`DATA_BITS`-1.
- Sample tick `S` = `OVERSAMPLE`/2-1, which is 7 at the default. Sample value = `rx_sync` at tick `S`, or the majority value under `RX_MAJORITY_EN` (see Configuration).
- IDLE: on a `baud_tick` where `rx_prev`=1 and `rx_sync`=0, go to START with `cnt`=0.
- START:
  - Sample 1 → pulse `start_error`, go to IDLE.
  - Sample 0 → continue. At `cnt` wrap, go to DATA with `bit_idx`=0.
- DATA:
  - At the sample point, shift the sample into the MSB of shift register `sr`, shifting right. The LSB therefore arrives first.
  - At `cnt` wrap, increment `bit_idx`. After bit `DATA_BITS`-1, go to STOP.
- STOP: at the sample point, do all of the following in one edge:
  - `data_out` ← `sr`
  - `stop_bit` ← sample
  - `check_stop` ← 1 for one cycle
  - go to IDLE
  The block re-arms at mid-stop-bit.
- Framing error (stop sample 0):
  - `check_stop` is still pulsed, with `stop_bit`=0; the downstream checker raises the error.
  - No new start is detected until the line has returned high and then falls.
- `baud_tick` low: state, `cnt` and sampling are frozen. Only the synchronizer runs.
- Reset at any time, including mid-frame:
  - the state returns to IDLE
  - `cnt`, `bit_idx`, `sr` and `data_out` are cleared to 0
  - `stop_bit` is set to 1, the synchronizer flops and `rx_prev` are set to 1
  - `check_stop`, `start_error` and `busy` are set to 0
  - the partial frame is discarded

## Timing
- Start-edge latency: 2 `clk` (synchronizer) plus up to 1 `baud_tick` period.
- Sample decision: on the `baud_tick` edge with `cnt`=`S`. With `RX_MAJORITY_EN` the decision is on the edge with `cnt`=`S`+1.
- The `check_stop` and `start_error` strobes are registered. They are high exactly one `clk`, during the cycle after the deciding `baud_tick` edge.
- `data_out` and `stop_bit` update on the same edge that raises `check_stop`.
- `busy` rises on the edge that enters START and falls on the edge that raises `check_stop` or `start_error`.
- Frame-to-frame: a start edge is accepted from the first `baud_tick` after STOP exits. Back-to-back frames with a 1-bit stop are supported.

## Configuration
- `RX_MAJORITY_EN` defined:
  - Each bit takes 3 samples, at `cnt`=`S`-1, `S` and `S`+1.
  - Value = majority of the 3, decided at `S`+1. This applies to the start, data and stop bits.
  - A single-tick glitch is rejected.
- `RX_MAJORITY_EN` undefined: single sample at `cnt`=`S`, with no extra sample registers.

## Test plan
Defaults, `baud_tick` every 4 `clk`.
- Frame 0xA5 with stop 1 → a single `check_stop` pulse; `data_out`=8'hA5, `stop_bit`=1; `start_error` stays 0; `busy` low afterwards.
- `rx_in` low for 3 ticks, then high → `start_error` pulses once; no `check_stop`; state back to IDLE; `data_out` unchanged.
- Frame 0x3C with stop bit 0 → `check_stop` pulses with `data_out`=8'h3C and `stop_bit`=0; the next valid frame 0x5A is received correctly after the line returns high.
- `rst` asserted for 1 `clk` during data bit 3 of 0xFF → all outputs at reset values; the following frame 0x5A gives `data_out`=8'h5A.
- Frame 0xFF with a 1-tick low glitch at `cnt`=`S` of bit 2:
  - macro defined → `data_out`=8'hFF
  - macro undefined → `data_out`=8'hFB
- Back-to-back frames 0x01 then 0x80 with no idle gap → two `check_stop` pulses 10 bit-periods apart, with `data_out` 8'h01 then 8'h80.
